// File: rtl/avmm_mailbox_master.sv
// Avalon-MM initiator for the SoC's 4-word mailbox window.
// Fabric logic queues read/write commands; they are issued in order, one
// strobe per cycle. Read data returns after a fixed latency into a buffered,
// back-pressurable response queue. Reads only issue when a response slot is
// guaranteed, so the response queue can never overflow.
module avmm_mailbox_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int CMD_DEPTH    = 4,
    parameter int RSP_DEPTH    = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic [ADDR_W-1:0] rsp_address,

    output logic              busy,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    localparam int CMD_PW = $clog2(CMD_DEPTH);
    localparam int CMD_CW = $clog2(CMD_DEPTH + 1);
    localparam int RSP_PW = $clog2(RSP_DEPTH);
    localparam int RSP_CW = $clog2(RSP_DEPTH + 1);

    // ------------------------------------------------------------------
    // Command queue storage and bookkeeping
    // ------------------------------------------------------------------
    logic              r_cmdWriteMem [CMD_DEPTH];
    logic [ADDR_W-1:0] r_cmdAddrMem  [CMD_DEPTH];
    logic [DATA_W-1:0] r_cmdDataMem  [CMD_DEPTH];
    logic [CMD_PW-1:0] r_cmdWrPtr;
    logic [CMD_PW-1:0] r_cmdRdPtr;
    logic [CMD_CW-1:0] r_cmdCount;

    logic              w_cmdReady;
    logic              w_cmdPush;
    logic              w_cmdPop;
    logic              w_cmdEmpty;

    // Head of the queue; falls through to the incoming command when empty
    logic              w_headValid;
    logic              w_headWrite;
    logic [ADDR_W-1:0] w_headAddr;
    logic [DATA_W-1:0] w_headData;

    // ------------------------------------------------------------------
    // Issue stage, read tag pipeline, credit
    // ------------------------------------------------------------------
    logic              r_mRead;
    logic              r_mWrite;
    logic [ADDR_W-1:0] r_mAddress;
    logic [DATA_W-1:0] r_mWritedata;

    logic              r_tagValid [READ_LATENCY];
    logic [ADDR_W-1:0] r_tagAddr  [READ_LATENCY];

    logic [RSP_CW-1:0] r_readsInFlight;
    logic [RSP_CW:0]   w_rspUsed;
    logic              w_creditOk;
    logic              w_issueRead;
    logic              w_issueWrite;

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_rspDataMem [RSP_DEPTH];
    logic [ADDR_W-1:0] r_rspAddrMem [RSP_DEPTH];
    logic [RSP_PW-1:0] r_rspWrPtr;
    logic [RSP_PW-1:0] r_rspRdPtr;
    logic [RSP_CW-1:0] r_rspCount;

    logic              w_rspValid;
    logic              w_rspPush;
    logic              w_rspPop;
    logic [ADDR_W-1:0] w_rspPushAddr;

    // Ready comes only from the registered count, so a full queue never
    // accepts in the same cycle that it pops.
    assign w_cmdReady = (r_cmdCount < CMD_CW'(CMD_DEPTH));
    assign w_cmdPush  = cmd_valid && w_cmdReady;
    assign w_cmdEmpty = (r_cmdCount == '0);
    assign w_cmdPop   = w_issueRead || w_issueWrite;

    // Select the oldest command: stored head, or the incoming one when empty
    always_comb begin
        w_headValid = 1'b0;
        w_headWrite = 1'b0;
        w_headAddr  = '0;
        w_headData  = '0;
        if (!w_cmdEmpty) begin
            w_headValid = 1'b1;
            w_headWrite = r_cmdWriteMem[r_cmdRdPtr];
            w_headAddr  = r_cmdAddrMem[r_cmdRdPtr];
            w_headData  = r_cmdDataMem[r_cmdRdPtr];
        end else if (cmd_valid) begin
            w_headValid = 1'b1;
            w_headWrite = cmd_write;
            w_headAddr  = cmd_address;
            w_headData  = cmd_writedata;
        end
    end

    // Space is reserved for every read from pop until its data lands
    assign w_rspUsed    = {1'b0, r_rspCount} + {1'b0, r_readsInFlight};
    assign w_creditOk   = (w_rspUsed < (RSP_CW + 1)'(RSP_DEPTH));
    assign w_issueWrite = w_headValid && w_headWrite;
    assign w_issueRead  = w_headValid && !w_headWrite && w_creditOk;

    // Command storage written on every accepted command
    always_ff @(posedge clk_clk) begin
        if (w_cmdPush) begin
            r_cmdWriteMem[r_cmdWrPtr] <= cmd_write;
            r_cmdAddrMem[r_cmdWrPtr]  <= cmd_address;
            r_cmdDataMem[r_cmdWrPtr]  <= cmd_writedata;
        end
    end

    // Command pointers and occupancy; a fall-through push+pop leaves count at 0
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cmdWrPtr <= '0;
            r_cmdRdPtr <= '0;
            r_cmdCount <= '0;
        end else begin
            if (w_cmdPush) begin
                r_cmdWrPtr <= r_cmdWrPtr + CMD_PW'(1);
            end
            if (w_cmdPop) begin
                r_cmdRdPtr <= r_cmdRdPtr + CMD_PW'(1);
            end
            case ({w_cmdPush, w_cmdPop})
                2'b10:   r_cmdCount <= r_cmdCount + CMD_CW'(1);
                2'b01:   r_cmdCount <= r_cmdCount - CMD_CW'(1);
                default: r_cmdCount <= r_cmdCount;
            endcase
        end
    end

    // Registered bus strobes; address/data hold when nothing is issued
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mRead      <= 1'b0;
            r_mWrite     <= 1'b0;
            r_mAddress   <= '0;
            r_mWritedata <= '0;
        end else begin
            r_mRead  <= w_issueRead;
            r_mWrite <= w_issueWrite;
            if (w_cmdPop) begin
                r_mAddress <= w_headAddr;
            end
            if (w_issueWrite) begin
                r_mWritedata <= w_headData;
            end
        end
    end

    // Tag pipeline marks the cycle in which each read's data is valid
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tagValid[i] <= 1'b0;
                r_tagAddr[i]  <= '0;
            end
        end else begin
            r_tagValid[0] <= r_mRead;
            r_tagAddr[0]  <= r_mAddress;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagAddr[i]  <= r_tagAddr[i-1];
            end
        end
    end

    assign w_rspPush     = r_tagValid[READ_LATENCY-1];
    assign w_rspPushAddr = r_tagAddr[READ_LATENCY-1];

    // Reads counted from pop until their data is written into the response queue
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_readsInFlight <= '0;
        end else begin
            case ({w_issueRead, w_rspPush})
                2'b10:   r_readsInFlight <= r_readsInFlight + RSP_CW'(1);
                2'b01:   r_readsInFlight <= r_readsInFlight - RSP_CW'(1);
                default: r_readsInFlight <= r_readsInFlight;
            endcase
        end
    end

    assign w_rspValid = (r_rspCount != '0);
    assign w_rspPop   = w_rspValid && rsp_ready;

    // Response storage captures returning read data with its address tag
    always_ff @(posedge clk_clk) begin
        if (w_rspPush) begin
            r_rspDataMem[r_rspWrPtr] <= m_readdata;
            r_rspAddrMem[r_rspWrPtr] <= w_rspPushAddr;
        end
    end

    // Response pointers and occupancy; credit keeps push from ever hitting full
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rspWrPtr <= '0;
            r_rspRdPtr <= '0;
            r_rspCount <= '0;
        end else begin
            if (w_rspPush) begin
                r_rspWrPtr <= r_rspWrPtr + RSP_PW'(1);
            end
            if (w_rspPop) begin
                r_rspRdPtr <= r_rspRdPtr + RSP_PW'(1);
            end
            case ({w_rspPush, w_rspPop})
                2'b10:   r_rspCount <= r_rspCount + RSP_CW'(1);
                2'b01:   r_rspCount <= r_rspCount - RSP_CW'(1);
                default: r_rspCount <= r_rspCount;
            endcase
        end
    end

    assign cmd_ready    = w_cmdReady;
    assign rsp_valid    = w_rspValid;
    assign rsp_readdata = w_rspValid ? r_rspDataMem[r_rspRdPtr] : '0;
    assign rsp_address  = w_rspValid ? r_rspAddrMem[r_rspRdPtr] : '0;

    assign m_read       = r_mRead;
    assign m_write      = r_mWrite;
    assign m_address    = r_mAddress;
    assign m_writedata  = r_mWritedata;

    assign busy = !w_cmdEmpty || r_mRead || r_mWrite ||
                  (r_readsInFlight != '0) || w_rspValid;

endmodule
